// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares the main-memory request port between the I-Cache read
// path and the D-Cache MSHR ports. It grants round-robin, allocates read/write
// serials from free pools, and routes read returns to the cache that owns the serial.
module cache_mem_arbiter #(
  parameter  int DC_PORT_NUM   = 2,
  parameter  int ADDR_WIDTH    = 32,
  parameter  int LINE_WIDTH    = 64,
  parameter  int RD_SERIAL_NUM = 3,
  parameter  int WR_SERIAL_NUM = 2,
  localparam int RS            = $clog2(RD_SERIAL_NUM),
  localparam int WS            = $clog2(WR_SERIAL_NUM)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DC_PORT_NUM-1:0]                 dcReqValid,
  input  logic [DC_PORT_NUM-1:0]                 dcReqWe,
  input  logic [DC_PORT_NUM-1:0][ADDR_WIDTH-1:0] dcReqAddr,
  input  logic [DC_PORT_NUM-1:0][LINE_WIDTH-1:0] dcReqData,
  output logic [DC_PORT_NUM-1:0]                 dcAck,
  output logic [RS-1:0]                          dcSerial,
  output logic [WS-1:0]                          dcWSerial,
  input  logic                                   icReqValid,
  input  logic [ADDR_WIDTH-1:0]                  icReqAddr,
  output logic                                   icAck,
  output logic [RS-1:0]                          icSerial,
  output logic                                   memReqValid,
  output logic                                   memReqWe,
  output logic [ADDR_WIDTH-1:0]                  memReqAddr,
  output logic [LINE_WIDTH-1:0]                  memReqData,
  output logic [RS-1:0]                          memReqSerial,
  output logic [WS-1:0]                          memReqWSerial,
  input  logic                                   memReqReady,
  input  logic                                   memResultValid,
  input  logic [RS-1:0]                          memResultSerial,
  input  logic [LINE_WIDTH-1:0]                  memResultData,
  input  logic                                   memRespValid,
  input  logic [WS-1:0]                          memRespSerial,
  output logic                                   icResultValid,
  output logic                                   dcResultValid,
  output logic [RS-1:0]                          resultSerial,
  output logic [LINE_WIDTH-1:0]                  resultData
);

  // Requesters 0..DC_PORT_NUM-1 are D-Cache ports, index DC_PORT_NUM is the I-Cache.
  localparam int REQ_NUM = DC_PORT_NUM + 1;
  localparam int PW      = $clog2(REQ_NUM);

  logic [RD_SERIAL_NUM-1:0] r_rd_free;
  logic [WR_SERIAL_NUM-1:0] r_wr_free;
  logic [RD_SERIAL_NUM-1:0] r_owner;    // 1: I-Cache owns the read serial
  logic [PW-1:0]            r_rr_ptr;

  logic                  w_rd_avail, w_wr_avail;
  logic [RS-1:0]         w_rd_sel;
  logic [WS-1:0]         w_wr_sel;
  logic                  w_out_free;
  logic [REQ_NUM-1:0]    w_elig, w_elig_rot;
  logic                  w_grant;
  logic [PW-1:0]         w_gidx, w_rr_next;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [LINE_WIDTH-1:0] w_sel_data;
  logic                  w_rd_grant, w_wr_grant;
  logic                  w_res_busy, w_res_owner, w_res_hit;
  logic                  w_resp_busy, w_resp_hit;

  assign w_out_free = !memReqValid || memReqReady;

  // Lowest free serial of each pool, taken from the registered masks only.
  always_comb begin
    w_rd_avail = 1'b0;
    w_rd_sel   = '0;
    for (int i = RD_SERIAL_NUM - 1; i >= 0; i--) begin
      if (r_rd_free[i]) begin
        w_rd_avail = 1'b1;
        w_rd_sel   = RS'(i);
      end
    end
    w_wr_avail = 1'b0;
    w_wr_sel   = '0;
    for (int i = WR_SERIAL_NUM - 1; i >= 0; i--) begin
      if (r_wr_free[i]) begin
        w_wr_avail = 1'b1;
        w_wr_sel   = WS'(i);
      end
    end
  end

  // Eligibility: each requester only needs a serial of its own type.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < DC_PORT_NUM; i++) begin
      w_elig[i] = !rst && w_out_free && dcReqValid[i] &&
                  (dcReqWe[i] ? w_wr_avail : w_rd_avail);
    end
    w_elig[DC_PORT_NUM] = !rst && w_out_free && icReqValid && w_rd_avail;
  end

  // Round-robin pick: rotate so rrPtr sits at bit 0, take the first set bit.
  always_comb begin
    int sum;
    w_elig_rot = REQ_NUM'({w_elig, w_elig} >> r_rr_ptr);
    w_grant    = 1'b0;
    w_gidx     = '0;
    sum        = 0;
    for (int k = 0; k < REQ_NUM; k++) begin
      if (!w_grant && w_elig_rot[k]) begin
        w_grant = 1'b1;
        sum     = int'(r_rr_ptr) + k;
        if (sum >= REQ_NUM) sum = sum - REQ_NUM;
        w_gidx  = PW'(sum);
      end
    end
    w_rr_next = (w_gidx == PW'(REQ_NUM - 1)) ? '0 : w_gidx + 1'b1;
  end

  // Payload mux for the granted requester; the I-Cache is the default (read, no data).
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = icReqAddr;
    w_sel_data = '0;
    for (int i = 0; i < DC_PORT_NUM; i++) begin
      if (w_gidx == PW'(i)) begin
        w_sel_we   = dcReqWe[i];
        w_sel_addr = dcReqAddr[i];
        w_sel_data = dcReqData[i];
      end
    end
    w_rd_grant = w_grant && !w_sel_we;
    w_wr_grant = w_grant && w_sel_we;
  end

  // Combinational acks and the serials handed to the granted requester.
  always_comb begin
    dcAck = '0;
    for (int i = 0; i < DC_PORT_NUM; i++) begin
      dcAck[i] = w_grant && (w_gidx == PW'(i));
    end
    icAck     = w_grant && (w_gidx == PW'(DC_PORT_NUM));
    dcSerial  = (|dcAck && !w_sel_we) ? w_rd_sel : '0;
    dcWSerial = (|dcAck && w_sel_we) ? w_wr_sel : '0;
    icSerial  = icAck ? w_rd_sel : '0;
  end

  // Completion lookup; a completion for a serial that is already free is stale.
  always_comb begin
    w_res_busy  = 1'b0;
    w_res_owner = 1'b0;
    for (int i = 0; i < RD_SERIAL_NUM; i++) begin
      if (memResultSerial == RS'(i)) begin
        w_res_busy  = !r_rd_free[i];
        w_res_owner = r_owner[i];
      end
    end
    w_resp_busy = 1'b0;
    for (int i = 0; i < WR_SERIAL_NUM; i++) begin
      if (memRespSerial == WS'(i)) w_resp_busy = !r_wr_free[i];
    end
    w_res_hit  = !rst && memResultValid && w_res_busy;
    w_resp_hit = !rst && memRespValid && w_resp_busy;
  end

  assign icResultValid = w_res_hit && w_res_owner;
  assign dcResultValid = w_res_hit && !w_res_owner;
  assign resultSerial  = rst ? '0 : memResultSerial;
  assign resultData    = rst ? '0 : memResultData;

  // Serial pools, ownership and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_free <= '1;
      r_wr_free <= '1;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
    end else begin
      for (int i = 0; i < RD_SERIAL_NUM; i++) begin
        if (w_res_hit && memResultSerial == RS'(i)) r_rd_free[i] <= 1'b1;
        if (w_rd_grant && w_rd_sel == RS'(i)) begin
          r_rd_free[i] <= 1'b0;
          r_owner[i]   <= icAck;
        end
      end
      for (int i = 0; i < WR_SERIAL_NUM; i++) begin
        if (w_resp_hit && memRespSerial == WS'(i)) r_wr_free[i] <= 1'b1;
        if (w_wr_grant && w_wr_sel == WS'(i)) r_wr_free[i] <= 1'b0;
      end
      if (w_grant) r_rr_ptr <= w_rr_next;
    end
  end

  // Output request register: loads on grant, holds until memory accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      memReqValid   <= 1'b0;
      memReqWe      <= 1'b0;
      memReqAddr    <= '0;
      memReqData    <= '0;
      memReqSerial  <= '0;
      memReqWSerial <= '0;
    end else if (w_grant) begin
      memReqValid   <= 1'b1;
      memReqWe      <= w_sel_we;
      memReqAddr    <= w_sel_addr;
      memReqData    <= w_sel_data;
      memReqSerial  <= w_sel_we ? '0 : w_rd_sel;
      memReqWSerial <= w_sel_we ? w_wr_sel : '0;
    end else if (memReqReady) begin
      memReqValid   <= 1'b0;
    end
  end

  // Flag completions that name an idle serial; they are dropped above.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(memResultValid && !w_res_busy))
        else $warning("read result for idle serial %0d dropped", memResultSerial);
      assert (!(memRespValid && !w_resp_busy))
        else $warning("write response for idle serial %0d dropped", memRespSerial);
    end
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares the single main-memory request port between the I-Cache read path and the D-Cache MSHR memory ports. Each cycle it grants at most one requester round-robin, allocates a read serial (MemAccessSerial) or write serial (MemWriteSerial) from free pools, and holds the granted request in an output register until memory accepts it. It records which side owns each outstanding read serial, so read results go back to the correct cache, and it recycles serials on read-result and write-response completion.

## Interface
- DC_PORT_NUM, 2: D-Cache memory ports (= MSHR_NUM)
- ADDR_WIDTH, 32: physical address width (PHY_ADDR_WIDTH)
- LINE_WIDTH, 64: line width (DCACHE_LINE_BIT_WIDTH)
- RD_SERIAL_NUM, 3: read serials (MSHR_NUM+1); RS = $clog2(RD_SERIAL_NUM) = 2
- WR_SERIAL_NUM, 2: write serials (MSHR_NUM); WS = $clog2(WR_SERIAL_NUM) = 1

Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dcReqValid  in  DC_PORT_NUM  per-port request valid
- dcReqWe  in  DC_PORT_NUM  per-port write (1) / read (0)
- dcReqAddr  in  DC_PORT_NUM×ADDR_WIDTH  per-port line address
- dcReqData  in  DC_PORT_NUM×LINE_WIDTH  per-port write data
- dcAck  out  DC_PORT_NUM  one-hot grant
- dcSerial  out  RS  read serial for the granted port
- dcWSerial  out  WS  write serial for the granted port
- icReqValid  in  1  I-Cache read request
- icReqAddr  in  ADDR_WIDTH  I-Cache line address
- icAck  out  1  I-Cache grant
- icSerial  out  RS  serial for the I-Cache grant
- memReqValid, memReqWe  out  1 each  registered memory request
- memReqAddr  out  ADDR_WIDTH; memReqData  out  LINE_WIDTH
- memReqSerial  out  RS; memReqWSerial  out  WS
- memReqReady  in  1  memory accepts memReq this cycle
- memResultValid  in  1; memResultSerial  in  RS; memResultData  in  LINE_WIDTH  read return
- memRespValid  in  1; memRespSerial  in  WS  write completion
- icResultValid, dcResultValid  out  1 each  routed read return
- resultSerial  out  RS; resultData  out  LINE_WIDTH  shared by both routed outputs

## Operation
- Requesters are indexed 0..DC_PORT_NUM-1 (D-Cache ports), then DC_PORT_NUM (I-Cache). I-Cache requests are always reads.
- A requester is eligible when it is valid, a free serial of its type exists (read pool for reads, write pool for writes), and the output register is free (!memReqValid || memReqReady).
- Grant goes to the first eligible index at or after rrPtr, wrapping. After a grant, rrPtr = granted index + 1, modulo DC_PORT_NUM+1. rrPtr does not move when nothing is granted.
- Serial allocation takes the lowest free index, decided from the registered free masks. An ineligible requester of one type does not block an eligible requester of the other type.
- On a read grant: rdFree[s] clears and owner[s] is set to 1 for I-Cache, 0 for D-Cache. On a write grant: wrFree[w] clears.
- Completion: memResultValid frees rdFree[memResultSerial]. memRespValid frees wrFree[memRespSerial]. A serial freed in cycle T can be allocated from cycle T+1.
- Routing: icResultValid = memResultValid & owner[serial]; dcResultValid = memResultValid & !owner[serial]. resultSerial and resultData pass through combinationally.
- A completion carrying a serial that is already free is ignored, causes no state change, and fires a simulation assertion.
- Reset values: rdFree all 1; wrFree all 1; owner 0; rrPtr 0; memReqValid 0; memReqWe, memReqAddr, memReqData and memReqSerial 0. Every ack and result output is 0 during reset.
- Reset mid-operation drops all outstanding serials and any pending memReq. Results that arrive after reset are treated as stale and ignored, per the rule above.

## Timing
- Grant cycle T: ack and serial are combinational in T. The request registers at the edge ending T, so memReqValid = 1 from T+1.
- memReqValid holds its payload stable until a cycle with memReqReady = 1. A new grant in that same cycle gives back-to-back issue: one request per cycle at full throughput.
- Read return routing has 0-cycle latency.
- Minimum serial turnaround: grant at T, result at T+2, the same serial can be re-granted at T+3.

## Test plan
- Contention: all three requesters request reads continuously, memReqReady = 1, results return at T+2 → grants follow order 0,1,2,0,… with one memReq per cycle. Serials are 0,1,2, then reuse as each is freed.
- Read pool exhausted: 3 reads granted with no results returned → a 4th read gets no ack. In the same cycle a D-Cache write is acked with wserial 0. After a result with serial 1 arrives, the next read gets serial 1 one cycle later.
- Backpressure: memReqReady = 0 for 4 cycles → memReqValid stays 1 with the payload unchanged and all acks are 0. When ready returns to 1, the next grant happens in that cycle.
- Routing: I-Cache gets serial 0 and D-Cache port 1 gets serial 1; results arrive for serial 1 then serial 0 → dcResultValid for serial 1, then icResultValid for serial 0, each carrying its data.
- Write recycling: 2 writes consume wserials 0 and 1, and a third write stalls. After memRespValid with serial 0, the third write is acked one cycle later with wserial 0.
- Reset mid-operation: assert rst with 2 reads outstanding and memReqValid = 1 → next cycle memReqValid = 0 and all pools are free. A stale result with serial 0 produces no routed valid.
